// File: rtl/breakout_pkg.sv
// Shared constants for the breakout audio back-end: sound codes, FSM states
// and the code-validity helper.
package breakout_pkg;

    localparam logic [2:0] SND_NONE   = 3'd0;
    localparam logic [2:0] SND_WALL   = 3'd1;
    localparam logic [2:0] SND_BRICK1 = 3'd2;
    localparam logic [2:0] SND_BRICK2 = 3'd3;
    localparam logic [2:0] SND_LOW    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        TONE2
    } state_t;

    // Only codes 1..4 map to a tone; 0 and 5..7 are silently dropped.
    function automatic logic snd_is_valid(input logic [2:0] code);
        return (code != SND_NONE) && (code <= SND_LOW);
    endfunction

endpackage

// File: rtl/breakout_sound_tick_sync.sv
// Two-flop synchroniser for the slow game clock plus a rising-edge detector.
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/breakout_sound.sv
// Breakout audio back-end: decodes the ball-stage sound code into a timed
// square wave. Define BREAKOUT_SOUND_CHIRP_EN for the two-step brick chirp.
module breakout_sound
    import breakout_pkg::*;
#(
    parameter int unsigned TONE_CYCLES = 2_500_000,
    parameter int unsigned HP_WALL     = 56_818,
    parameter int unsigned HP_BRICK1   = 37_879,
    parameter int unsigned HP_BRICK2   = 28_409,
    parameter int unsigned HP_LOW      = 113_636
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic [2:0] sound_code,
    input  logic       erase_enable,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] current_code
);

    localparam logic [21:0] DUR_LAST = 22'(TONE_CYCLES - 1);
`ifdef BREAKOUT_SOUND_CHIRP_EN
    localparam logic [21:0] HALF_LAST = 22'(TONE_CYCLES / 2 - 1);
`endif

    state_t      state_q, state_d;
    logic        spk_q, spk_d;
    logic [2:0]  code_q, code_d;
    logic [2:0]  last_q, last_d;
    logic [16:0] hp_q, hp_d;
    logic [16:0] hp_cnt_q, hp_cnt_d;
    logic [21:0] dur_q, dur_d;
    logic [21:0] dur_last;
    logic        tick_rise;
    logic        trigger;

    tick_sync u_tick_sync (
        .clk    (clk),
        .rst_n  (reset),
        .async_i(game_tick),
        .rise_o (tick_rise)
    );

    function automatic logic [16:0] half_period(input logic [2:0] code);
        case (code)
            SND_WALL:   return 17'(HP_WALL);
            SND_BRICK1: return 17'(HP_BRICK1);
            SND_BRICK2: return 17'(HP_BRICK2);
            default:    return 17'(HP_LOW);
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        spk_d    = spk_q;
        code_d   = code_q;
        last_d   = last_q;
        hp_d     = hp_q;
        hp_cnt_d = hp_cnt_q;
        dur_d    = dur_q;
        dur_last = DUR_LAST;
        trigger  = tick_rise && ((sound_code != last_q) || erase_enable)
                   && snd_is_valid(sound_code);

        if (tick_rise) begin
            last_d = sound_code;
        end

`ifdef BREAKOUT_SOUND_CHIRP_EN
        if (code_q == SND_BRICK2) begin
            dur_last = HALF_LAST;
        end
`endif

        if (state_q != IDLE) begin
            if (hp_cnt_q == hp_q - 17'd1) begin
                hp_cnt_d = '0;
                spk_d    = ~spk_q;
            end else begin
                hp_cnt_d = hp_cnt_q + 17'd1;
            end

            if (dur_q == dur_last) begin
`ifdef BREAKOUT_SOUND_CHIRP_EN
                if (state_q == TONE && code_q == SND_BRICK2) begin
                    state_d  = TONE2;
                    hp_d     = 17'(HP_BRICK1);
                    hp_cnt_d = '0;
                    dur_d    = '0;
                    spk_d    = 1'b1;
                end else
`endif
                begin
                    state_d  = IDLE;
                    spk_d    = 1'b0;
                    code_d   = SND_NONE;
                    hp_cnt_d = '0;
                    dur_d    = '0;
                end
            end else begin
                dur_d = dur_q + 22'd1;
            end
        end

        // Applied last so a trigger coinciding with expiry restarts the tone.
        if (trigger) begin
            state_d  = TONE;
            hp_d     = half_period(sound_code);
            hp_cnt_d = '0;
            dur_d    = '0;
            code_d   = sound_code;
            spk_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            spk_q    <= 1'b0;
            code_q   <= SND_NONE;
            last_q   <= SND_NONE;
            hp_q     <= '0;
            hp_cnt_q <= '0;
            dur_q    <= '0;
        end else begin
            state_q  <= state_d;
            spk_q    <= spk_d;
            code_q   <= code_d;
            last_q   <= last_d;
            hp_q     <= hp_d;
            hp_cnt_q <= hp_cnt_d;
            dur_q    <= dur_d;
        end
    end

    assign speaker      = spk_q;
    assign busy         = (state_q != IDLE);
    assign current_code = code_q;

endmodule

// File: tb/tb_breakout_sound.sv
// Scoreboard bench for breakout_sound: expected per-cycle outputs are queued
// from a closed-form waveform description and popped one per clock.
module tb_breakout_sound;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       game_tick = 1'b0;
    logic [2:0] sound_code = 3'd0;
    logic       erase_enable = 1'b0;
    logic       speaker;
    logic       busy;
    logic [2:0] current_code;

    typedef struct packed {
        logic       spk;
        logic       bsy;
        logic [2:0] code;
    } obs_t;

    obs_t exp_q[$];
    obs_t exp_o;
    obs_t got;
    int   checks = 0;
    int   errors = 0;
    int   tick_left = 0;

    breakout_sound #(
        .TONE_CYCLES(100),
        .HP_WALL    (5),
        .HP_BRICK1  (4),
        .HP_BRICK2  (3),
        .HP_LOW     (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_tick   (game_tick),
        .sound_code  (sound_code),
        .erase_enable(erase_enable),
        .speaker     (speaker),
        .busy        (busy),
        .current_code(current_code)
    );

    always #5 clk = ~clk;

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, 1'b0, 3'd0});
    endtask

    // Tone sample k of half-period hp: high for k/hp even, low otherwise.
    task automatic push_tone(input logic [2:0] code, input int hp, input int k0, input int cnt);
        for (int k = k0; k < k0 + cnt; k++)
            exp_q.push_back('{((k / hp) % 2) == 0, 1'b1, code});
    endtask

    task automatic drive_tick(input logic [2:0] code, input logic erase);
        sound_code   = code;
        erase_enable = erase;
        game_tick    = 1'b1;
        tick_left    = 4;
    endtask

    task automatic tick_step();
        if (tick_left > 0) begin
            tick_left--;
            if (tick_left == 0) begin
                game_tick    = 1'b0;
                erase_enable = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        push_idle(10);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) game_tick = ~game_tick;
            if (i == 5) begin
                reset     = 1'b1;
                game_tick = 1'b0;
            end
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
        end
    endtask

    task automatic test_single_tone();
        push_idle(2); push_tone(3'd1, 5, 0, 100); push_idle(10);
        for (int i = 0; i < 112; i++) begin
            if (i == 0) drive_tick(3'd1, 1'b0);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL single_tone cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_hold_code();
        push_idle(2); push_tone(3'd2, 4, 0, 100); push_idle(10);
        for (int i = 0; i < 112; i++) begin
            if (i == 0 || i == 32) drive_tick(3'd2, 1'b0);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL hold_code cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_erase_retrigger();
        push_idle(2); push_tone(3'd2, 4, 0, 32); push_tone(3'd2, 4, 0, 100); push_idle(10);
        for (int i = 0; i < 144; i++) begin
            if (i == 0 || i == 32) drive_tick(3'd2, 1'b1);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL erase_retrigger cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_switch();
        push_idle(2); push_tone(3'd4, 10, 0, 42); push_tone(3'd1, 5, 0, 100); push_idle(10);
        for (int i = 0; i < 154; i++) begin
            if (i == 0) drive_tick(3'd4, 1'b0);
            if (i == 42) drive_tick(3'd1, 1'b0);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL switch cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_back_to_back();
        push_idle(2); push_tone(3'd1, 5, 0, 100); push_tone(3'd1, 5, 0, 100); push_idle(10);
        for (int i = 0; i < 212; i++) begin
            if (i == 0 || i == 100) drive_tick(3'd1, 1'b1);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    // Codes 6 then 0 play nothing; the following code 1 only triggers if
    // last_code followed the ignored ticks away from 1.
    task automatic test_invalid();
        push_idle(22); push_tone(3'd1, 5, 0, 100); push_idle(10);
        for (int i = 0; i < 132; i++) begin
            if (i == 0)  drive_tick(3'd6, 1'b0);
            if (i == 10) drive_tick(3'd0, 1'b0);
            if (i == 20) drive_tick(3'd1, 1'b0);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL invalid cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_reset_abort();
        push_idle(2); push_tone(3'd4, 10, 0, 30); push_idle(12);
        for (int i = 0; i < 44; i++) begin
            if (i == 0)  drive_tick(3'd4, 1'b0);
            if (i == 32) reset = 1'b0;
            if (i == 34) reset = 1'b1;
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset_abort cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    task automatic test_brick2();
        push_idle(2);
`ifdef BREAKOUT_SOUND_CHIRP_EN
        push_tone(3'd3, 3, 0, 50); push_tone(3'd3, 4, 0, 50);
`else
        push_tone(3'd3, 3, 0, 100);
`endif
        push_idle(10);
        for (int i = 0; i < 112; i++) begin
            if (i == 0) drive_tick(3'd3, 1'b0);
            @(posedge clk); #1;
            exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
            got = '{speaker, busy, current_code};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL brick2 cyc %0d: got spk=%b busy=%b code=%0d, want spk=%b busy=%b code=%0d",
                         i, got.spk, got.bsy, got.code, exp_o.spk, exp_o.bsy, exp_o.code);
            end
            tick_step();
        end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_hold_code();
        test_erase_retrigger();
        test_switch();
        test_back_to_back();
        test_invalid();
        test_reset_abort();
        test_brick2();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
